// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

  // Width of the FSM state encoding presented on state_o.
  localparam int STATE_W = 3;

  // Sequencer states; encodings are visible on state_o for debug.
  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL    = 3'd0,
    ST_WAIT_LOCK    = 3'd1,
    ST_STABLE_CHECK = 3'd2,
    ST_RUNNING      = 3'd3
  } pll_seq_state_t;

  // Increment that sticks at maxv instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] maxv);
    return (val >= maxv) ? maxv : val + 32'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit.
// Synchronous reset clears every stage to 0.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Fewer than two stages gives no metastability protection, so clamp.
  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] r_sync;

  // Shift the async input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[N-2:0], d};
  end

  assign q = r_sync[N-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for lock with a
// timeout, qualifies lock stability, then releases the downstream reset.
// Loss of lock or a relock request restarts the whole sequence.
//
// relock_req is a single-cycle pulse with no handshake: it is acted on in
// the cycle it is high (outside RESET_PLL) and needs no acknowledge.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 8
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst_out,
  output logic               ready,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   lock_loss_count,
  output logic [CNT_W-1:0]   timeout_count
);

  // One shared phase counter is enough: only one phase is timed at a time
  // and it is cleared on every state change.
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]    RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;

  logic           w_lk_s;
  pll_seq_state_t r_state;
  pll_seq_state_t w_next_state;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_next;
  logic           w_timeout_inc;
  logic           w_loss_inc;
  logic           r_pll_rst;
  logic           r_sys_rst;
  logic           r_ready;
  logic [CNT_W-1:0] r_lock_loss_count;
  logic [CNT_W-1:0] r_timeout_count;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_locked (
    .clk(refclk),
    .rst(rst),
    .d  (pll_locked),
    .q  (w_lk_s)
  );

  // Next-state, phase-counter and event-count decisions.
  always_comb begin
    w_next_state  = r_state;
    w_timeout_inc = 1'b0;
    w_loss_inc    = 1'b0;
    w_cnt_next    = '0;
    case (r_state)
      ST_RESET_PLL: begin
        if (r_cnt == RST_LAST) w_next_state = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Relock beats everything; lock beats a simultaneous timeout.
        if (relock_req)            w_next_state = ST_RESET_PLL;
        else if (w_lk_s)           w_next_state = ST_STABLE_CHECK;
        else if (r_cnt == TO_LAST) begin
          w_next_state  = ST_RESET_PLL;
          w_timeout_inc = 1'b1;
        end
      end
      ST_STABLE_CHECK: begin
        // A dropout here is just an unqualified lock, not a lock loss.
        if (relock_req)                w_next_state = ST_RESET_PLL;
        else if (!w_lk_s)              w_next_state = ST_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_next_state = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (relock_req)   w_next_state = ST_RESET_PLL;
        else if (!w_lk_s) begin
          w_next_state = ST_RESET_PLL;
          w_loss_inc   = 1'b1;
        end
      end
      default: w_next_state = ST_RESET_PLL;
    endcase

    if (w_next_state != r_state)  w_cnt_next = '0;
    else if (r_state == ST_RUNNING) w_cnt_next = r_cnt;
    else                            w_cnt_next = r_cnt + 1'b1;
  end

  // State and phase counter registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= ST_RESET_PLL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Registered outputs decoded from the next state so they change together
  // with the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_pll_rst <= (w_next_state == ST_RESET_PLL);
      r_sys_rst <= (w_next_state != ST_RUNNING);
      r_ready   <= (w_next_state == ST_RUNNING);
    end
  end

  // Saturating event counters for timeouts and lock losses.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_timeout_count   <= '0;
      r_lock_loss_count <= '0;
    end else begin
      if (w_timeout_inc)
        r_timeout_count <= CNT_W'(sat_inc(32'(r_timeout_count), 32'(CNT_SAT)));
      if (w_loss_inc)
        r_lock_loss_count <= CNT_W'(sat_inc(32'(r_lock_loss_count), 32'(CNT_SAT)));
    end
  end

  assign pll_rst         = r_pll_rst;
  assign sys_rst_out     = r_sys_rst;
  assign ready           = r_ready;
  assign state_o         = r_state;
  assign lock_loss_count = r_lock_loss_count;
  assign timeout_count   = r_timeout_count;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus
// random lock/relock/reset traffic, every cycle compared to a phase/age
// reference model through an expected-value queue.
module tb_pll_lock_sequencer;

  localparam int PRC = 4;
  localparam int LTO = 20;
  localparam int STC = 8;
  localparam int SS  = 2;
  localparam int CW  = 8;
  localparam int SAT = 255;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst;
  logic          sys_rst_out;
  logic          ready;
  logic [2:0]    state_o;
  logic [CW-1:0] lock_loss_count;
  logic [CW-1:0] timeout_count;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LTO),
    .STABLE_CYCLES (STC),
    .SYNC_STAGES   (SS),
    .CNT_W         (CW)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .relock_req     (relock_req),
    .pll_rst        (pll_rst),
    .sys_rst_out    (sys_rst_out),
    .ready          (ready),
    .state_o        (state_o),
    .lock_loss_count(lock_loss_count),
    .timeout_count  (timeout_count)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase = which step of the sequence we are in, age = whole cycles
  // already spent in it; the synchronizer is a plain delay line.
  int   m_phase;
  int   m_age;
  int   m_loss;
  int   m_to;
  logic m_sync_q[$];
  logic [21:0] exp_q[$];

  task automatic model_reset();
    m_phase = P_RST;
    m_age   = 0;
    m_loss  = 0;
    m_to    = 0;
    m_sync_q.delete();
    for (int k = 0; k < SS; k++) m_sync_q.push_back(1'b0);
  endtask

  task automatic enter(input int ph);
    m_phase = ph;
    m_age   = 0;
  endtask

  task automatic model_step(input logic r, input logic l, input logic q);
    logic lk_s;
    if (r) begin
      model_reset();
      return;
    end
    lk_s = m_sync_q[SS-1];
    m_sync_q.push_front(l);
    void'(m_sync_q.pop_back());
    case (m_phase)
      P_RST: begin
        if (m_age + 1 == PRC) enter(P_WAIT);
        else m_age++;
      end
      P_WAIT: begin
        if (q) enter(P_RST);
        else if (lk_s) enter(P_STAB);
        else if (m_age + 1 == LTO) begin
          m_to = (m_to < SAT) ? m_to + 1 : SAT;
          enter(P_RST);
        end else m_age++;
      end
      P_STAB: begin
        if (q) enter(P_RST);
        else if (!lk_s) enter(P_WAIT);
        else if (m_age + 1 == STC) enter(P_RUN);
        else m_age++;
      end
      default: begin
        if (q) enter(P_RST);
        else if (!lk_s) begin
          m_loss = (m_loss < SAT) ? m_loss + 1 : SAT;
          enter(P_RST);
        end
      end
    endcase
  endtask

  function automatic logic [21:0] model_pack();
    return {(m_phase == P_RST), (m_phase != P_RUN), (m_phase == P_RUN),
            3'(m_phase), 8'(m_loss), 8'(m_to)};
  endfunction

  // ---------------- driver ----------------
  // Drive inputs at the negedge, let the DUT and model step on the
  // posedge, compare on the following negedge.
  task automatic cycle(input logic r, input logic l, input logic q);
    logic [21:0] e;
    rst        = r;
    pll_locked = l;
    relock_req = q;
    @(posedge refclk);
    model_step(r, l, q);
    exp_q.push_back(model_pack());
    @(negedge refclk);
    e = exp_q.pop_front();
    check("pll_rst",   pll_rst,         e[21]);
    check("sys_rst",   sys_rst_out,     e[20]);
    check("ready",     ready,           e[19]);
    check("state",     state_o,         e[18:16]);
    check("loss_cnt",  lock_loss_count, e[15:8]);
    check("to_cnt",    timeout_count,   e[7:0]);
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (state_o != target && n < budget) begin
      cycle(1'b0, 1'b1, 1'b0);
      n++;
    end
    check(tag, state_o, target);
  endtask

  // ---------------- stimulus ----------------
  int   n;
  int   lat;
  logic seen;
  logic lk_r;
  logic rq_r;
  logic rr_r;

  initial begin
    model_reset();

    // Reset state
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    check("rst_state",   state_o,         0);
    check("rst_pll_rst", pll_rst,         1);
    check("rst_sys_rst", sys_rst_out,     1);
    check("rst_ready",   ready,           0);
    check("rst_loss",    lock_loss_count, 0);
    check("rst_to",      timeout_count,   0);

    // 1: PLL reset pulse width, then lock latency to ready
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (pll_rst) n++;
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("t1_pll_rst_len", n, PRC);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      cycle(1'b0, 1'b1, 1'b0);
      lat++;
      if (ready) seen = 1'b1;
    end
    check("t1_ready_latency", lat, SS + STC + 1);
    check("t1_sys_rst_low", sys_rst_out, 0);

    // 3: one-cycle lock dropout while running
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("t3_ready_still", ready, 1);
    cycle(1'b0, 1'b1, 1'b0);
    check("t3_ready_drop", ready, 0);
    check("t3_sys_rst", sys_rst_out, 1);
    check("t3_loss_cnt", lock_loss_count, 1);
    n = pll_rst ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (pll_rst) n++;
    end
    check("t3_pulse_len", n, PRC);

    // 4: glitch during stable check is not a loss and restarts qualification
    cycle(1'b0, 1'b1, 1'b1);
    wait_state(3'd2, 40, "t4_reach_stable");
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("t4_back_wait", state_o, 1);
    check("t4_loss_same", lock_loss_count, 1);
    check("t4_to_same", timeout_count, 0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      cycle(1'b0, 1'b1, 1'b0);
      lat++;
      if (ready) seen = 1'b1;
    end
    check("t4_fresh_stable", lat, STC + 1);

    // 5: relock in the same cycle lk_s falls: no loss counted
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t5_state", state_o, 0);
    check("t5_loss_same", lock_loss_count, 1);
    cycle(1'b0, 1'b1, 1'b0);

    // 2: no lock at all -> repeated timeouts
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 70; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (i == 49) check("t2_to_at_50", timeout_count, 2);
    end
    check("t2_to_at_70", timeout_count, 2);
    check("t2_ready_low", ready, 0);

    // 6: timeout counter saturation, then reset mid stable check
    repeat (300 * (PRC + LTO)) cycle(1'b0, 1'b0, 1'b0);
    check("t6_to_sat", timeout_count, SAT);
    wait_state(3'd2, 60, "t6_reach_stable");
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("t6_rst_state",   state_o,         0);
    check("t6_rst_pll_rst", pll_rst,         1);
    check("t6_rst_sys_rst", sys_rst_out,     1);
    check("t6_rst_ready",   ready,           0);
    check("t6_rst_loss",    lock_loss_count, 0);
    check("t6_rst_to",      timeout_count,   0);

    // Random traffic: slowly toggling lock, rare relocks and resets
    lk_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) lk_r = ~lk_r;
      rq_r = ($urandom_range(299) == 0);
      rr_r = ($urandom_range(1499) == 0);
      cycle(rr_r, lk_r, rq_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
